viz_packet_tx: RTL and testbench

VIZ_PACKET_TX -- requirements
Module: viz_packet_tx

---
 rtl/viz_pkg.sv | 22 ++
 rtl/viz_packet_tx_decim.sv | 26 ++
 rtl/viz_packet_tx.sv | 126 ++++++++++++
 tb/tb_viz_packet_tx.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viz_pkg.sv
// Shared constants, FSM state type and sample-to-byte conversion for the viz packet transmitter.
package viz_pkg;

    localparam logic [7:0] VIZ_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] VIZ_IDLE_BYTE = 8'h80;
    localparam int unsigned VIZ_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT
    } viz_state_t;

    // Top 8 bits of a w-bit signed sample with the sign bit flipped (offset binary).
    function automatic logic [7:0] to_viz_byte(input logic [VIZ_MAX_W-1:0] s, input int unsigned w);
        logic [VIZ_MAX_W-1:0] top;
        top = s >> (w - 8);
        return {~top[7], top[6:0]};
    endfunction

endpackage

// File: rtl/viz_packet_tx_decim.sv
// Sample-tick decimator: flags the tick on which the modulo-DECIM count reaches DECIM-1.
module viz_decim #(
    parameter int DECIM = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_tick,
    output logic capture
);

    localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

    logic [CW-1:0] cnt;

    assign capture = sample_tick && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (sample_tick) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/viz_packet_tx.sv
// Decimated audio snapshot packetiser feeding a byte UART; VIZ_PKT_CHECKSUM_EN appends an XOR checksum byte.
module viz_packet_tx
    import viz_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 24,
    parameter int DECIM    = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_tick,
    input  logic [NUM_CH*SAMPLE_W-1:0]   audio_data,
    input  logic                         tx_done,
    output logic [7:0]                   uart_din,
    output logic                         uart_tx_start,
    output logic                         pkt_active,
    output logic [7:0]                   overrun_cnt
);

`ifdef VIZ_PKT_CHECKSUM_EN
    localparam int unsigned PKT_LEN = NUM_CH + 3;
`else
    localparam int unsigned PKT_LEN = NUM_CH + 2;
`endif
    localparam int unsigned IW = $clog2(NUM_CH + 3);

    logic            capture;
    viz_state_t      state;
    logic [IW-1:0]   idx;
    logic [7:0]      seq;
    logic [7:0]      snap      [NUM_CH];
    logic [7:0]      snap_next [NUM_CH];
    logic [7:0]      cur_byte;

    viz_decim #(.DECIM(DECIM)) u_decim (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_tick(sample_tick),
        .capture    (capture)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign snap_next[g] = to_viz_byte(VIZ_MAX_W'(audio_data[g*SAMPLE_W +: SAMPLE_W]), SAMPLE_W);
    end

`ifdef VIZ_PKT_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = seq;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            csum = csum ^ snap[ch];
        end
    end
`endif

    // Byte order: sync, sequence, channel bytes, optional checksum.
    always_comb begin
        cur_byte = VIZ_SYNC_BYTE;
        if (idx == IW'(1)) begin
            cur_byte = seq;
        end
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (idx == IW'(ch + 2)) begin
                cur_byte = snap[ch];
            end
        end
`ifdef VIZ_PKT_CHECKSUM_EN
        if (idx == IW'(NUM_CH + 2)) begin
            cur_byte = csum;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            seq           <= '0;
            overrun_cnt   <= '0;
            uart_din      <= VIZ_IDLE_BYTE;
            uart_tx_start <= 1'b0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                snap[ch] <= VIZ_IDLE_BYTE;
            end
        end else begin
            uart_tx_start <= 1'b0;
            // Any capture outside IDLE, including the cycle of the final tx_done, is a drop.
            if (capture && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (capture) begin
                        snap  <= snap_next;
                        idx   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    uart_din <= cur_byte;
                    state    <= START;
                end
                START: begin
                    uart_tx_start <= 1'b1;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (idx == IW'(PKT_LEN - 1)) begin
                            seq   <= seq + 8'd1;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pkt_active = (state != IDLE);

endmodule

// File: tb/tb_viz_packet_tx.sv
// Scoreboard bench for viz_packet_tx: reference packets from an arithmetic model, checked by an independent monitor.
module tb_viz_packet_tx;

    localparam int NCH = 2;
    localparam int SW  = 24;
    localparam int DEC = 10;
`ifdef VIZ_PKT_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int LEN   = NCH + 2 + int'(CSUM);
    localparam int LEN_B = 1 + 2 + int'(CSUM);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n;
    logic                sample_tick;
    logic [NCH*SW-1:0]   audio_data;
    logic                tx_done;
    logic [7:0]          uart_din;
    logic                uart_tx_start;
    logic                pkt_active;
    logic [7:0]          overrun_cnt;

    logic                tick_b;
    logic [7:0]          data_b;
    logic                done_b;
    logic [7:0]          din_b;
    logic                start_b;
    logic                active_b;
    logic [7:0]          ovr_b;

    viz_packet_tx #(.NUM_CH(NCH), .SAMPLE_W(SW), .DECIM(DEC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_tick  (sample_tick),
        .audio_data   (audio_data),
        .tx_done      (tx_done),
        .uart_din     (uart_din),
        .uart_tx_start(uart_tx_start),
        .pkt_active   (pkt_active),
        .overrun_cnt  (overrun_cnt)
    );

    viz_packet_tx #(.NUM_CH(1), .SAMPLE_W(8), .DECIM(1)) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_tick  (tick_b),
        .audio_data   (data_b),
        .tx_done      (done_b),
        .uart_din     (din_b),
        .uart_tx_start(start_b),
        .pkt_active   (active_b),
        .overrun_cnt  (ovr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int  tick_mod   = 0;
    bit  model_busy = 1'b0;
    int  bytes_left = 0;
    int  seq_m      = 0;
    int  exp_ovr    = 0;
    int  pkts_done  = 0;
    int  dly        = 20;
    int  timer      = -1;
    bit  hold_done  = 1'b0;
    bit  rand_data  = 1'b0;

    function automatic logic [7:0] viz_of(input longint unsigned s, input int w);
        longint unsigned m;
        m = 64'd1 << w;
        return 8'(((s + (m >> 1)) % m) >> (w - 8));
    endfunction

    task automatic model_tick();
        logic [7:0] b;
        logic [7:0] c;
        if (tick_mod == DEC - 1) begin
            if (model_busy) begin
                if (exp_ovr < 255) exp_ovr++;
            end else begin
                c = 8'(seq_m);
                exp_q.push_back(8'hA5);
                exp_q.push_back(8'(seq_m));
                for (int ch = 0; ch < NCH; ch++) begin
                    b = viz_of(longint'(audio_data[ch*SW +: SW]), SW);
                    exp_q.push_back(b);
                    c = c ^ b;
                end
                if (CSUM) exp_q.push_back(c);
                model_busy = 1'b1;
                bytes_left = LEN;
            end
        end
        tick_mod = (tick_mod + 1) % DEC;
    endtask

    task automatic model_done();
        bytes_left--;
        if (bytes_left == 0) begin
            model_busy = 1'b0;
            seq_m      = (seq_m + 1) % 256;
            pkts_done++;
        end
    endtask

    // One clock of stimulus: optional tick plus the UART responder; tick is modelled before tx_done.
    task automatic cycle(input bit tk);
        @(posedge clk);
        #1;
        sample_tick = tk;
        tx_done     = 1'b0;
        if (tk && rand_data) begin
            for (int ch = 0; ch < NCH; ch++) audio_data[ch*SW +: SW] = SW'($urandom());
        end
        if (uart_tx_start) begin
            timer = dly;
        end else if (timer > 0 && !hold_done) begin
            timer--;
            if (timer == 0) begin
                tx_done = 1'b1;
                timer   = -1;
            end
        end
        if (tk) model_tick();
        if (tx_done) model_done();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (model_busy && n < budget) begin
            cycle(1'b0);
            n++;
        end
        if (model_busy) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: packet still open after %0d cycles, expected idle", budget);
        end
        repeat (3) cycle(1'b0);
        check("idle_pkt_active", 64'(pkt_active), 64'd0);
        check("all_bytes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    logic [7:0] cur;
    bit         cur_v = 1'b0;

    // Monitor: every start pulse must carry the next expected byte, held until its tx_done.
    always @(negedge clk) begin
        if (!reset_n) begin
            cur_v = 1'b0;
        end else begin
            if (uart_tx_start) begin
                got_q.push_back(uart_din);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got start with din=%0h expected no start", uart_din);
                end else begin
                    cur   = exp_q.pop_front();
                    cur_v = 1'b1;
                    check("tx_byte", 64'(uart_din), 64'(cur));
                end
            end else if (tx_done && cur_v) begin
                check("din_held", 64'(uart_din), 64'(cur));
                check("active_in_wait", 64'(pkt_active), 64'd1);
            end
        end
    end

    task automatic run_b(input bit tick_on_last, output logic [7:0] bytes [LEN_B]);
        int n;
        for (int i = 0; i < LEN_B; i++) begin
            n = 0;
            while (!start_b && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!start_b) begin
                checks++;
                errors++;
                $display("FAIL b_start_timeout: no start for byte %0d within 100 cycles", i);
            end
            bytes[i] = din_b;
            repeat (3) @(posedge clk);
            #1;
            done_b = 1'b1;
            if (tick_on_last && i == LEN_B - 1) begin
                tick_b = 1'b1;
                data_b = 8'h11;
            end
            @(posedge clk);
            #1;
            done_b = 1'b0;
            tick_b = 1'b0;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] pb [LEN_B];
        logic [7:0] exp_d [$];
        int n;

        reset_n     = 1'b0;
        sample_tick = 1'b0;
        tx_done     = 1'b0;
        audio_data  = '0;
        tick_b      = 1'b0;
        data_b      = '0;
        done_b      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_din", 64'(uart_din), 64'h80);
        check("rst_tx_start", 64'(uart_tx_start), 64'd0);
        check("rst_pkt_active", 64'(pkt_active), 64'd0);
        check("rst_overrun", 64'(overrun_cnt), 64'd0);
        reset_n = 1'b1;

        // Directed packet with extreme / known sample values
`ifdef VIZ_PKT_CHECKSUM_EN
        audio_data = {24'h000000, 24'h123456};
        exp_d = '{8'hA5, 8'h00, 8'h92, 8'h80, 8'h12};
`else
        audio_data = {24'h800000, 24'h7FFFFF};
        exp_d = '{8'hA5, 8'h00, 8'hFF, 8'h00};
`endif
        got_q.delete();
        dly = 20;
        repeat (DEC) cycle(1'b1);
        drain(2000);
        check("pkt1_start_count", 64'(got_q.size()), 64'(LEN));
        for (int i = 0; i < LEN; i++) begin
            if (i < got_q.size()) check("pkt1_literal", 64'(got_q[i]), 64'(exp_d[i]));
        end

        // Overrun: tx_done withheld while 30 more ticks arrive
        got_q.delete();
        rand_data = 1'b1;
        repeat (DEC) cycle(1'b1);
        hold_done = 1'b1;
        repeat (30) cycle(1'b1);
        cycle(1'b0);
        check("overrun_3", 64'(overrun_cnt), 64'd3);
        check("overrun_model", 64'(overrun_cnt), 64'(exp_ovr));
        hold_done = 1'b0;
        drain(2000);
        if (got_q.size() > 1) check("pkt2_seq", 64'(got_q[1]), 64'h01);
        else check("pkt2_len", 64'(got_q.size()), 64'(LEN));

        // Randomised traffic long enough to wrap the sequence byte
        n = 0;
        while (pkts_done < 262 && n < 40000) begin
            dly = int'($urandom_range(1, 4));
            cycle($urandom_range(0, 1) == 1);
            n++;
        end
        if (pkts_done < 262) begin
            checks++;
            errors++;
            $display("FAIL random_budget: got %0d packets expected at least 262", pkts_done);
        end
        drain(2000);
        check("rand_overrun", 64'(overrun_cnt), 64'(exp_ovr));

        // Saturation of the overrun counter
        n = 0;
        while (!model_busy && n < 40) begin
            cycle(1'b1);
            n++;
        end
        hold_done = 1'b1;
        repeat (2600) cycle(1'b1);
        cycle(1'b0);
        check("overrun_sat", 64'(overrun_cnt), 64'd255);
        hold_done = 1'b0;
        drain(2000);

        // Asynchronous reset during WAIT of byte 2
        got_q.delete();
        dly = 20;
        n = 0;
        while (!model_busy && n < 40) begin
            cycle(1'b1);
            n++;
        end
        n = 0;
        while (got_q.size() < 3 && n < 500) begin
            cycle(1'b0);
            n++;
        end
        check("byte2_started", 64'(got_q.size()), 64'd3);
        repeat (5) cycle(1'b0);
        @(posedge clk);
        #3;
        reset_n     = 1'b0;
        tx_done     = 1'b0;
        sample_tick = 1'b0;
        #1;
        check("arst_uart_din", 64'(uart_din), 64'h80);
        check("arst_tx_start", 64'(uart_tx_start), 64'd0);
        check("arst_pkt_active", 64'(pkt_active), 64'd0);
        check("arst_overrun", 64'(overrun_cnt), 64'd0);
        exp_q.delete();
        model_busy = 1'b0;
        bytes_left = 0;
        seq_m      = 0;
        tick_mod   = 0;
        exp_ovr    = 0;
        timer      = -1;
        #2;
        reset_n = 1'b1;
        got_q.delete();
        repeat (60) cycle(1'b0);
        check("no_start_after_rst", 64'(got_q.size()), 64'd0);
        repeat (DEC) cycle(1'b1);
        drain(2000);
        if (got_q.size() > 1) check("post_rst_seq", 64'(got_q[1]), 64'h00);
        else check("post_rst_len", 64'(got_q.size()), 64'(LEN));

        // DECIM=1: capture coincident with the final tx_done is dropped
        data_b = 8'h3C;
        @(posedge clk);
        #1;
        tick_b = 1'b1;
        @(posedge clk);
        #1;
        tick_b = 1'b0;
        run_b(1'b1, pb);
        check("b_p1_sync", 64'(pb[0]), 64'hA5);
        check("b_p1_seq", 64'(pb[1]), 64'h00);
        check("b_p1_ch0", 64'(pb[2]), 64'hBC);
        if (CSUM) check("b_p1_csum", 64'(pb[LEN_B-1]), 64'hBC);
        check("b_drop_overrun", 64'(ovr_b), 64'd1);
        n = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (start_b) n++;
        end
        check("b_no_start_after_drop", 64'(n), 64'd0);
        check("b_idle", 64'(active_b), 64'd0);
        data_b = 8'h80;
        tick_b = 1'b1;
        @(posedge clk);
        #1;
        tick_b = 1'b0;
        run_b(1'b0, pb);
        check("b_p2_seq", 64'(pb[1]), 64'h01);
        check("b_p2_ch0", 64'(pb[2]), 64'h00);
        check("b_overrun_kept", 64'(ovr_b), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
